// File: rtl/clock_calendar_core.sv
// -----------------------------------------------------------------------------
// clock_calendar_core
//
// Timekeeping core for the digital clock. One block holds the 1 Hz divider,
// per-button debounce, the hh:mm:ss counters and the day/month/year calendar
// with true month lengths. All fields are binary; the display stages
// (bin2bcd, seg7led) sit downstream.
//
// Optional feature macro: CAL_LEAP_EN
//   defined   -> February has 29 days when year[1:0]==0 (exact for 2000-2099)
//   undefined -> February always has 28 days, no leap logic is built
//
// Parameters:
//   CLK_HZ          clock cycles per tick (>= 4)
//   DEBOUNCE_CYCLES consecutive differing samples needed to flip a button (>= 2)
//
// Ports:
//   clk_100MHz                     system clock
//   reset                          synchronous, active-high reset
//   inc_sec, inc_min, inc_hour     raw time-set buttons, active-high
//   inc_day, inc_month, inc_year   raw date-set buttons, active-high
//   mode_12h                       1 = 12-hour hour mapping on the output
//   tick_1Hz                       one-cycle pulse every CLK_HZ cycles
//   end_of_day                     one-cycle pulse with the first 00:00:00
//   sec, min, hour                 binary time (hour remapped in 12 h mode)
//   pm                             internal hour >= 12
//   day, month, year               binary date, year 0..99 = 2000..2099
// -----------------------------------------------------------------------------
module clock_calendar_core #(
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       inc_day,
    input  logic       inc_month,
    input  logic       inc_year,
    input  logic       mode_12h,
    output logic       tick_1Hz,
    output logic       end_of_day,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       pm,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year
);

    localparam int DIV_W = $clog2(CLK_HZ);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    // Days in month m; leap selects the 29-day February.
    function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
        logic [7:0] len;
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: len = 8'd30;
            8'd2:                    len = leap ? 8'd29 : 8'd28;
            default:                 len = 8'd31;
        endcase
        return len;
    endfunction

    // ------------------------------------------------------------------
    // 1 Hz divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_1Hz = (div_q == DIV_LAST);

    // ------------------------------------------------------------------
    // Debounce, one lane per button.
    // Bit order: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year.
    // ------------------------------------------------------------------
    logic [5:0] btn_raw;
    logic [5:0] set_pulse;

    assign btn_raw = {inc_year, inc_month, inc_day, inc_hour, inc_min, inc_sec};

    for (genvar gi = 0; gi < 6; gi++) begin : g_db
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            lvl_q, lvl_d;
        logic            lvl_prev_q;

        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (btn_raw[gi] != lvl_q) begin
                // The sample that completes the run flips the level.
                if (cnt_q == DB_LAST) begin
                    lvl_d = ~lvl_q;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk_100MHz) begin
            if (reset) begin
                cnt_q      <= '0;
                lvl_q      <= 1'b0;
                lvl_prev_q <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                lvl_q      <= lvl_d;
                lvl_prev_q <= lvl_q;
            end
        end

        // Press edge only; releases are silent.
        assign set_pulse[gi] = lvl_q & ~lvl_prev_q;
    end

    // ------------------------------------------------------------------
    // Time and calendar state
    // ------------------------------------------------------------------
    logic [7:0] sec_q, min_q, hour_q, day_q, month_q, year_q;
    logic [7:0] sec_d, min_d, hour_d, day_d, month_d, year_d;
    logic       pend_q, pend_d;
    logic       eod_q, eod_d;

    logic [7:0] sec_set, min_set, hour_set, day_set, mon_set, yr_set;
    logic [7:0] len_set, len_cur;
    logic       leap_set, leap_cur;
    logic       any_set, tick_due;
    logic       sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;

    always_comb begin
        any_set  = |set_pulse;
        tick_due = tick_1Hz | pend_q;

        // Set path: every field wraps on its own, no carries.
        sec_set  = sec_q;
        min_set  = min_q;
        hour_set = hour_q;
        mon_set  = month_q;
        yr_set   = year_q;
        if (set_pulse[0]) sec_set  = (sec_q   == 8'd59) ? 8'd0 : sec_q   + 8'd1;
        if (set_pulse[1]) min_set  = (min_q   == 8'd59) ? 8'd0 : min_q   + 8'd1;
        if (set_pulse[2]) hour_set = (hour_q  == 8'd23) ? 8'd0 : hour_q  + 8'd1;
        if (set_pulse[4]) mon_set  = (month_q == 8'd12) ? 8'd1 : month_q + 8'd1;
        if (set_pulse[5]) yr_set   = (year_q  == 8'd99) ? 8'd0 : year_q  + 8'd1;

`ifdef CAL_LEAP_EN
        leap_set = (yr_set[1:0] == 2'b00);
        leap_cur = (year_q[1:0] == 2'b00);
`else
        leap_set = 1'b0;
        leap_cur = 1'b0;
`endif

        // Day wrap and clamp both use the month/year after this cycle's sets,
        // so a simultaneous month/year change is honoured.
        len_set = month_len(mon_set, leap_set);
        day_set = day_q;
        if (set_pulse[3]) day_set = (day_q >= len_set) ? 8'd1 : day_q + 8'd1;
        if (day_set > len_set) day_set = len_set;

        // Tick path carry chain.
        len_cur   = month_len(month_q, leap_cur);
        sec_wrap  = (sec_q == 8'd59);
        min_wrap  = sec_wrap && (min_q == 8'd59);
        hour_wrap = min_wrap && (hour_q == 8'd23);
        day_wrap  = hour_wrap && (day_q >= len_cur);
        mon_wrap  = day_wrap && (month_q == 8'd12);

        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        pend_d  = pend_q;
        eod_d   = 1'b0;

        if (any_set) begin
            // Set pulses win; a coinciding tick is parked until a quiet cycle.
            sec_d   = sec_set;
            min_d   = min_set;
            hour_d  = hour_set;
            day_d   = day_set;
            month_d = mon_set;
            year_d  = yr_set;
            pend_d  = pend_q | tick_1Hz;
        end else if (tick_due) begin
            pend_d = 1'b0;
            eod_d  = hour_wrap;
            sec_d  = sec_wrap ? 8'd0 : sec_q + 8'd1;
            if (sec_wrap)  min_d   = (min_q == 8'd59)   ? 8'd0 : min_q + 8'd1;
            if (min_wrap)  hour_d  = (hour_q == 8'd23)  ? 8'd0 : hour_q + 8'd1;
            if (hour_wrap) day_d   = day_wrap           ? 8'd1 : day_q + 8'd1;
            if (day_wrap)  month_d = (month_q == 8'd12) ? 8'd1 : month_q + 8'd1;
            if (mon_wrap)  year_d  = (year_q == 8'd99)  ? 8'd0 : year_q + 8'd1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sec_q   <= 8'd0;
            min_q   <= 8'd0;
            hour_q  <= 8'd0;
            day_q   <= 8'd1;
            month_q <= 8'd1;
            year_q  <= 8'd0;
            pend_q  <= 1'b0;
            eod_q   <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            pend_q  <= pend_d;
            eod_q   <= eod_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The 12 h mapping is display-only; state stays 0..23.
    // ------------------------------------------------------------------
    always_comb begin
        hour = hour_q;
        if (mode_12h) begin
            if (hour_q == 8'd0) begin
                hour = 8'd12;
            end else if (hour_q > 8'd12) begin
                hour = hour_q - 8'd12;
            end
        end
    end

    assign pm         = (hour_q >= 8'd12);
    assign sec        = sec_q;
    assign min        = min_q;
    assign day        = day_q;
    assign month      = month_q;
    assign year       = year_q;
    assign end_of_day = eod_q;

endmodule

// File: tb/tb_clock_calendar_core.sv
// -----------------------------------------------------------------------------
// tb_clock_calendar_core
//
// Self-checking bench for clock_calendar_core (CLK_HZ=4, DEBOUNCE_CYCLES=2).
// The reference model keeps time as seconds-of-day plus a calendar date and
// applies scheduled set pulses and ticks edge by edge. Every output is
// compared on every falling edge. Honours CAL_LEAP_EN like the design.
// -----------------------------------------------------------------------------
module tb_clock_calendar_core;

    localparam int CLK_HZ = 4;
    localparam int DB     = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] btn;
    logic       mode_12h;
    logic       tick_1Hz, end_of_day, pm;
    logic [7:0] sec, min, hour, day, month, year;

    always #5 clk = ~clk;

    clock_calendar_core #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .inc_sec    (btn[0]),
        .inc_min    (btn[1]),
        .inc_hour   (btn[2]),
        .inc_day    (btn[3]),
        .inc_month  (btn[4]),
        .inc_year   (btn[5]),
        .mode_12h   (mode_12h),
        .tick_1Hz   (tick_1Hz),
        .end_of_day (end_of_day),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .pm         (pm),
        .day        (day),
        .month      (month),
        .year       (year)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int cyc;            // edges since the last reset edge
    int tod;            // seconds of day 0..86399
    int m_day, m_mon, m_year;
    bit pending;
    bit exp_eod;
    int sched[6];       // edge at which each button's set pulse lands, -1 none

    function automatic int dim(input int m, input int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
`ifdef CAL_LEAP_EN
        if (m == 2 && (y % 4) == 0) return 29;
`endif
        return t[m-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0; tod = 0; m_day = 1; m_mon = 1; m_year = 0;
        pending = 0; exp_eod = 0;
        for (int b = 0; b < 6; b++) sched[b] = -1;
    endtask

    task automatic model_sets(input logic [5:0] m);
        int s  = tod % 60;
        int mi = (tod / 60) % 60;
        int h  = tod / 3600;
        if (m[0]) s  = (s + 1) % 60;
        if (m[1]) mi = (mi + 1) % 60;
        if (m[2]) h  = (h + 1) % 24;
        tod = h * 3600 + mi * 60 + s;
        if (m[4]) m_mon  = m_mon % 12 + 1;
        if (m[5]) m_year = (m_year + 1) % 100;
        if (m[3]) m_day  = (m_day >= dim(m_mon, m_year)) ? 1 : m_day + 1;
        if (m_day > dim(m_mon, m_year)) m_day = dim(m_mon, m_year);
    endtask

    task automatic model_tick();
        tod = (tod + 1) % 86400;
        if (tod == 0) begin
            exp_eod = 1;
            m_day++;
            if (m_day > dim(m_mon, m_year)) begin
                m_day = 1;
                m_mon++;
                if (m_mon > 12) begin
                    m_mon  = 1;
                    m_year = (m_year + 1) % 100;
                end
            end
        end
    endtask

    // One clock: advance the model at the rising edge, compare at the falling edge.
    task automatic cycle();
        logic [5:0] setm;
        bit tick_now;
        int h, hd;
        @(posedge clk);
        exp_eod = 0;
        if (reset) begin
            model_reset();
        end else begin
            cyc++;
            setm = '0;
            for (int b = 0; b < 6; b++) begin
                if (sched[b] == cyc) begin
                    setm[b]  = 1'b1;
                    sched[b] = -1;
                end
            end
            tick_now = ((cyc % CLK_HZ) == 0);
            if (setm != 0) begin
                model_sets(setm);
                if (tick_now) pending = 1;
            end else if (tick_now || pending) begin
                model_tick();
                pending = 0;
            end
        end
        @(negedge clk);
        h  = tod / 3600;
        hd = h;
        if (mode_12h) hd = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        chk("sec",        sec,        tod % 60);
        chk("min",        min,        (tod / 60) % 60);
        chk("hour",       hour,       hd);
        chk("pm",         pm,         (h >= 12) ? 1 : 0);
        chk("day",        day,        m_day);
        chk("month",      month,      m_mon);
        chk("year",       year,       m_year);
        chk("tick_1Hz",   tick_1Hz,   (!reset && (cyc % CLK_HZ) == CLK_HZ - 1) ? 1 : 0);
        chk("end_of_day", end_of_day, exp_eod ? 1 : 0);
        mode_12h = 1'($urandom_range(0, 1));
    endtask

    // Raise the buttons in mask for hold samples, then release long enough
    // for the debounced level to return to 0.
    task automatic press(input logic [5:0] mask, input int hold);
        int e0 = cyc;
        btn = mask;
        if (hold >= DB) begin
            for (int b = 0; b < 6; b++) if (mask[b]) sched[b] = e0 + DB + 1;
        end
        repeat (hold) cycle();
        btn = '0;
        repeat (DB) cycle();
        $display("press mask=%b hold=%0d -> %02d:%02d:%02d %02d/%02d/%02d",
                 mask, hold, tod / 3600, (tod / 60) % 60, tod % 60, m_day, m_mon, m_year);
    endtask

    task automatic set_hm(input int h, input int m);
        int guard = 0;
        while (((tod / 3600) != h || ((tod / 60) % 60) != m) && guard < 500) begin
            if ((tod / 3600) != h) press(6'b000100, DB);
            else                   press(6'b000010, DB);
            guard++;
        end
        chk("set_hm_bound", guard < 500, 1);
    endtask

    task automatic set_date(input int d, input int m, input int y);
        int guard = 0;
        while ((m_day != d || m_mon != m || m_year != y) && guard < 500) begin
            if (m_mon != m)       press(6'b010000, DB);
            else if (m_year != y) press(6'b100000, DB);
            else                  press(6'b001000, DB);
            guard++;
        end
        chk("set_date_bound", guard < 500, 1);
    endtask

    task automatic wait_midnight();
        int n = 0;
        bit seen = 0;
        while (!seen && n < 600) begin
            cycle();
            seen = exp_eod;
            n++;
        end
        chk("midnight_bound", seen, 1);
        $display("midnight -> %02d:%02d:%02d %02d/%02d/%02d",
                 tod / 3600, (tod / 60) % 60, tod % 60, m_day, m_mon, m_year);
    endtask

    initial begin
        logic [5:0] m;
        reset    = 1'b1;
        btn      = '0;
        mode_12h = 1'b0;
        model_reset();
        repeat (2) cycle();
        reset = 1'b0;
        $display("reset released");

        // Free-running ticks with no buttons.
        repeat (3 * CLK_HZ) cycle();

        // Debounce: glitch ignored, long hold counts exactly once.
        press(6'b000010, 1);
        press(6'b000010, 10);

        // Set pulse landing on a tick edge: tick deferred one cycle.
        while (((cyc + DB + 1) % CLK_HZ) != 0) cycle();
        press(6'b000100, DB);

        // Full rollover to 01/01/00.
        set_date(31, 12, 99);
        set_hm(23, 59);
        wait_midnight();
        repeat (3) cycle();

        // Clamp: 31/01 plus a month press.
        set_date(31, 1, 24);
        press(6'b010000, DB);

        // February end in year 24.
        set_date(28, 2, 24);
        set_hm(23, 59);
        wait_midnight();
        set_hm(23, 59);
        wait_midnight();

        // Randomized presses with random phase against the tick.
        for (int i = 0; i < 150; i++) begin
            m = 6'($urandom_range(1, 63));
            if (m[3]) m = 6'b001000;
            press(m, $urandom_range(1, DB + 3));
            repeat ($urandom_range(0, 3)) cycle();
        end

        // Reset mid-operation with a partially counted button.
        btn = 6'b000001;
        cycle();
        btn   = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        $display("mid-run reset applied");
        repeat (2 * CLK_HZ + 2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
